// File: rtl/present_cipher_core_if.sv
// Handshake bundle between the PRESENT core and its host: key load, data in, result out.
interface present_cipher_core_if #(
  parameter int unsigned KEY_WIDTH = 80
);
  logic                 inKeyWr;
  logic [KEY_WIDTH-1:0] inKeyData;
  logic                 outKeyReady;
  logic                 inDataValid;
  logic                 outDataReady;
  logic                 inMode;
  logic [63:0]          inData;
  logic                 outResValid;
  logic                 inResReady;
  logic [63:0]          outResData;
  logic                 outBusy;

  modport master (
    output inKeyWr, inKeyData, inDataValid, inMode, inData, inResReady,
    input  outKeyReady, outDataReady, outResValid, outResData, outBusy
  );

  modport slave (
    input  inKeyWr, inKeyData, inDataValid, inMode, inData, inResReady,
    output outKeyReady, outDataReady, outResValid, outResData, outBusy
  );
endinterface

// File: rtl/present_cipher_core.sv
// Iterative PRESENT-80/128 core, one round per clock, encrypt or decrypt per block.
// The expanded final round key is cached so decryption can run the schedule backwards.
module present_cipher_core #(
  parameter int unsigned KEY_WIDTH = 80,
  parameter int unsigned ROUNDS    = 31
) (
  input logic                  inClk,
  input logic                  inRstN,
  present_cipher_core_if.slave bus
);

  if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_key_width
    $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_cipher_core: ROUNDS must be in 1..31");
  end

  localparam int unsigned XOR_LO   = (KEY_WIDTH == 128) ? 62 : 15;
  localparam logic [4:0]  LAST_RND = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, KEY_EXP, RUN, DONE} state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    y = '0;
    case (x)
      4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
      4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
      4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
      4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; 4'hF: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    y = '0;
    case (x)
      4'h0: y = 4'h5; 4'h1: y = 4'hE; 4'h2: y = 4'hF; 4'h3: y = 4'h8;
      4'h4: y = 4'hC; 4'h5: y = 4'h1; 4'h6: y = 4'h2; 4'h7: y = 4'hD;
      4'h8: y = 4'hB; 4'h9: y = 4'h4; 4'hA: y = 4'h6; 4'hB: y = 4'h3;
      4'hC: y = 4'h0; 4'hD: y = 4'h7; 4'hE: y = 4'h9; 4'hF: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int unsigned n = 0; n < 16; n++) o[4*n +: 4] = sbox(s[4*n +: 4]);
    return o;
  endfunction

  function automatic logic [63:0] s_layer_inv(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int unsigned n = 0; n < 16; n++) o[4*n +: 4] = sbox_inv(s[4*n +: 4]);
    return o;
  endfunction

  // Bit b moves to 16*b mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int unsigned b = 0; b < 63; b++) o[6'((b * 16) % 63)] = s[b];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [63:0] p_layer_inv(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int unsigned b = 0; b < 63; b++) o[b] = s[6'((b * 16) % 63)];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [KEY_WIDTH-1:0] key_fwd(input logic [KEY_WIDTH-1:0] k,
                                                    input logic [4:0] i);
    logic [KEY_WIDTH-1:0] r;
    r = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
    r[KEY_WIDTH-1 -: 4] = sbox(r[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) r[KEY_WIDTH-5 -: 4] = sbox(r[KEY_WIDTH-5 -: 4]);
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ i;
    return r;
  endfunction

  function automatic logic [KEY_WIDTH-1:0] key_inv(input logic [KEY_WIDTH-1:0] k,
                                                    input logic [4:0] i);
    logic [KEY_WIDTH-1:0] r;
    r = k;
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ i;
    r[KEY_WIDTH-1 -: 4] = sbox_inv(r[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) r[KEY_WIDTH-5 -: 4] = sbox_inv(r[KEY_WIDTH-5 -: 4]);
    return {r[60:0], r[KEY_WIDTH-1:61]};
  endfunction

  state_e               state_q;
  logic [KEY_WIDTH-1:0] k1_q, last_q, rk_q;
  logic [63:0]          st_q, res_q;
  logic [4:0]           cnt_q;
  logic                 mode_q, key_rdy_q, res_vld_q, busy_q;

  logic [KEY_WIDTH-1:0] key_fwd_d, key_inv_d;
  logic [63:0]          st_enc_d, st_dec_d;
  logic                 data_rdy, accept;

  always_comb begin
    key_fwd_d = key_fwd(rk_q, cnt_q);
    key_inv_d = key_inv(rk_q, cnt_q);
    st_enc_d  = p_layer(s_layer(st_q ^ rk_q[KEY_WIDTH-1 -: 64]));
    st_dec_d  = s_layer_inv(p_layer_inv(st_q)) ^ key_inv_d[KEY_WIDTH-1 -: 64];
  end

  assign data_rdy = (state_q == IDLE) && key_rdy_q && !bus.inKeyWr;
  assign accept   = bus.inDataValid && data_rdy;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q   <= IDLE;
      k1_q      <= '0;
      last_q    <= '0;
      rk_q      <= '0;
      st_q      <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      key_rdy_q <= 1'b0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.inKeyWr) begin
            rk_q      <= bus.inKeyData;
            k1_q      <= bus.inKeyData;
            key_rdy_q <= 1'b0;
            cnt_q     <= 5'd1;
            busy_q    <= 1'b1;
            state_q   <= KEY_EXP;
          end else if (accept) begin
            mode_q  <= bus.inMode;
            busy_q  <= 1'b1;
            state_q <= RUN;
            if (bus.inMode) begin
              st_q  <= bus.inData ^ last_q[KEY_WIDTH-1 -: 64];
              rk_q  <= last_q;
              cnt_q <= LAST_RND;
            end else begin
              st_q  <= bus.inData;
              rk_q  <= k1_q;
              cnt_q <= 5'd1;
            end
          end
        end
        KEY_EXP: begin
          rk_q <= key_fwd_d;
          if (cnt_q == LAST_RND) begin
            last_q    <= key_fwd_d;
            key_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        RUN: begin
          // Encrypt counts up through the schedule; decrypt walks it back down.
          if (!mode_q) begin
            st_q <= st_enc_d;
            rk_q <= key_fwd_d;
            if (cnt_q == LAST_RND) begin
              res_q     <= st_enc_d ^ key_fwd_d[KEY_WIDTH-1 -: 64];
              res_vld_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end else begin
            st_q <= st_dec_d;
            rk_q <= key_inv_d;
            if (cnt_q == 5'd1) begin
              res_q     <= st_dec_d;
              res_vld_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
        end
        DONE: begin
          if (bus.inResReady) begin
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.outKeyReady  = key_rdy_q;
  assign bus.outDataReady = data_rdy;
  assign bus.outResValid  = res_vld_q;
  assign bus.outResData   = res_q;
  assign bus.outBusy      = busy_q;

endmodule
